// File: rtl/multiplier_sched.sv
// Round-robin scheduler that time-shares one combinational carry-save multiplier
// array between two requesters, holding operands stable for SETTLE cycles.

module multiplier #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [2*N:0] p
);

  localparam int W = 2 * N + 1;

  logic [W-1:0] sum_v;
  logic [W-1:0] carry_v;
  logic [W-1:0] pp;
  logic [W-1:0] sum_n;
  logic [W-1:0] carry_n;
  logic         ripple_c;

  // Each partial-product row is folded into a redundant sum/carry pair by a
  // row of full adders; a ripple adder resolves the pair into the product.
  always_comb begin
    sum_v    = '0;
    carry_v  = '0;
    pp       = '0;
    sum_n    = '0;
    carry_n  = '0;
    ripple_c = 1'b0;
    p        = '0;
    for (int i = 0; i < N; i++) begin
      pp      = W'(a & {N{b[i]}}) << i;
      sum_n   = sum_v ^ carry_v ^ pp;
      carry_n = ((sum_v & carry_v) | (sum_v & pp) | (carry_v & pp)) << 1;
      sum_v   = sum_n;
      carry_v = carry_n;
    end
    for (int k = 0; k < W; k++) begin
      p[k]     = sum_v[k] ^ carry_v[k] ^ ripple_c;
      ripple_c = (sum_v[k] & carry_v[k]) | (sum_v[k] & ripple_c) |
                 (carry_v[k] & ripple_c);
    end
  end

endmodule

module multiplier_sched #(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N:0]   rsp_p,
  output logic           busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] op_a_q, op_a_d;
  logic [N-1:0] op_b_q, op_b_d;
  logic         id_q, id_d;
  logic         last_id_q, last_id_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [2*N:0] rsp_p_q, rsp_p_d;
  logic         busy_q, busy_d;

  logic         grant;
  logic         can_grant;
  logic         accept;
  logic [2*N:0] array_p;

  multiplier #(.N(N)) u_array (
    .a (op_a_q),
    .b (op_b_q),
    .p (array_p)
  );

  // On a tie the requester that did not win last time is preferred.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_id_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign can_grant  = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = can_grant && !grant;
  assign req1_ready = can_grant && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    last_id_d   = last_id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d    = grant ? req1_a : req0_a;
          op_b_d    = grant ? req1_b : req0_b;
          id_d      = grant;
          last_id_d = grant;
          cnt_d     = CNT_LOAD;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_p_d     = array_p;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_p_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      last_id_q   <= last_id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multiplier_sched.sv
// Self-checking bench for multiplier_sched: directed scenarios, a randomized
// run against a transaction-level model, and exhaustive sweeps at SETTLE=1/3.

module tb_multiplier_sched;

  localparam int N      = 4;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0;
  logic         req0_ready;
  logic [N-1:0] req0_a = '0;
  logic [N-1:0] req0_b = '0;
  logic         req1_valid = 1'b0;
  logic         req1_ready;
  logic [N-1:0] req1_a = '0;
  logic [N-1:0] req1_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic [2*N:0] rsp_p;
  logic         busy;

  logic         sw_valid [2];
  logic         sw_ready0 [2];
  logic         sw_ready1 [2];
  logic [N-1:0] sw_a = '0;
  logic [N-1:0] sw_b = '0;
  logic         sw_zero = 1'b0;
  logic [N-1:0] sw_zero_op = '0;
  logic         sw_rsp_ready = 1'b1;
  logic         sw_rsp_valid [2];
  logic         sw_rsp_id [2];
  logic [2*N:0] sw_rsp_p [2];
  logic         sw_busy [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplier_sched #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .busy(busy)
  );

  multiplier_sched #(.N(N), .SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .req0_valid(sw_valid[0]), .req0_ready(sw_ready0[0]), .req0_a(sw_a), .req0_b(sw_b),
    .req1_valid(sw_zero), .req1_ready(sw_ready1[0]), .req1_a(sw_zero_op), .req1_b(sw_zero_op),
    .rsp_valid(sw_rsp_valid[0]), .rsp_ready(sw_rsp_ready), .rsp_id(sw_rsp_id[0]),
    .rsp_p(sw_rsp_p[0]), .busy(sw_busy[0])
  );

  multiplier_sched #(.N(N), .SETTLE(3)) dut_s3 (
    .clk(clk), .rst(rst),
    .req0_valid(sw_valid[1]), .req0_ready(sw_ready0[1]), .req0_a(sw_a), .req0_b(sw_b),
    .req1_valid(sw_zero), .req1_ready(sw_ready1[1]), .req1_a(sw_zero_op), .req1_b(sw_zero_op),
    .rsp_valid(sw_rsp_valid[1]), .rsp_ready(sw_rsp_ready), .rsp_id(sw_rsp_id[1]),
    .rsp_p(sw_rsp_p[1]), .busy(sw_busy[1])
  );

  function automatic logic [2*N:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned r;
    r = int'(a) * int'(b);
    return (2*N+1)'(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (rsp_valid !== 1'b1 && n < 50);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %0b expected 0", rsp_valid); end
    checks++; if (rsp_p !== '0) begin errors++; $display("[TB] FAIL reset_rsp_p got %0h expected 0", rsp_p); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_id got %0b expected 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_readies got %0b%0b expected 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL single_ready got %0b%0b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got %0b expected 1", busy); end
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1 || n != SETTLE) begin
      errors++; $display("[TB] FAIL single_latency got %0d (valid %0b) expected %0d", n, rsp_valid, SETTLE);
    end
    checks++; if (rsp_p !== 9'h0E1) begin errors++; $display("[TB] FAIL single_p got %0h expected e1", rsp_p); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL single_id got %0b expected 0", rsp_id); end
    checks++; if (rsp_p[2*N] !== 1'b0) begin errors++; $display("[TB] FAIL single_carry got %0b expected 0", rsp_p[2*N]); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_release got valid %0b busy %0b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int rise [4];
    logic exp_last;
    logic exp_id;
    do_reset();
    exp_last = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
    for (int r = 0; r < 4; r++) begin
      exp_id = ~exp_last;
      wait_rsp(n);
      rise[r] = cyc;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_timeout got 0 expected 1 (resp %0d)", r); end
      checks++; if (rsp_id !== exp_id) begin errors++; $display("[TB] FAIL rr_id got %0b expected %0b (resp %0d)", rsp_id, exp_id, r); end
      checks++; if (rsp_p !== (exp_id ? 9'd63 : 9'd15)) begin
        errors++; $display("[TB] FAIL rr_p got %0d expected %0d (resp %0d)", rsp_p, exp_id ? 63 : 15, r);
      end
      if (r > 0) begin
        checks++; if (rise[r] - rise[r-1] != SETTLE + 2) begin
          errors++; $display("[TB] FAIL rr_interval got %0d expected %0d", rise[r] - rise[r-1], SETTLE + 2);
        end
      end
      exp_last = exp_id;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
    tick();
    req0_valid = 1'b0;
    wait_rsp(n);
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd3;
    for (int i = 0; i < 10; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_a = 4'($urandom_range(0, 15));
      req0_b = 4'($urandom_range(0, 15));
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_p !== 9'd42) begin
        errors++; $display("[TB] FAIL bp_hold got valid %0b p %0d expected 1 42", rsp_valid, rsp_p);
      end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_readies got %0b%0b expected 00", req0_ready, req1_ready);
      end
      tick();
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_same_cycle got %0b expected 0", req1_ready); end
    tick();
    checks++; if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_next_accept got ready %0b valid %0b expected 1 0", req1_ready, rsp_valid);
    end
    tick();
    req1_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_busy got %0b expected 1", busy); end
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_p !== 9'd6) begin
      errors++; $display("[TB] FAIL bp_req1 got valid %0b id %0b p %0d expected 1 1 6", rsp_valid, rsp_id, rsp_p);
    end
    tick();
  endtask

  task automatic test_operand_hold();
    int n;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd11;
    tick();
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0;
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1 || rsp_p !== 9'd99) begin
      errors++; $display("[TB] FAIL hold_p got valid %0b p %0d expected 1 99", rsp_valid, rsp_p);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd6;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got busy %0b valid %0b expected 0 0", busy, rsp_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_rsp got 1 expected 0"); end
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
    req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd5;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_tie got %0b%0b expected 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_p !== 9'd6) begin
      errors++; $display("[TB] FAIL mid_after got valid %0b id %0b p %0d expected 1 0 6", rsp_valid, rsp_id, rsp_p);
    end
    tick();
  endtask

  task automatic test_random();
    logic pending, m_last, exp_any, exp_win, exp_rv, acc, hs, exp_id;
    logic [2*N:0] exp_p;
    int age;
    do_reset();
    pending = 1'b0; m_last = 1'b1; age = 0; exp_id = 1'b0; exp_p = '0;
    for (int c = 0; c < 300; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
      req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_any = !pending && (req0_valid || req1_valid);
      exp_win = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      exp_rv  = pending && (age >= SETTLE);
      checks++; if (req0_ready !== (exp_any && !exp_win) || req1_ready !== (exp_any && exp_win)) begin
        errors++; $display("[TB] FAIL rand_ready got %0b%0b expected %0b%0b (cycle %0d)",
                           req0_ready, req1_ready, exp_any && !exp_win, exp_any && exp_win, c);
      end
      checks++; if (rsp_valid !== exp_rv) begin
        errors++; $display("[TB] FAIL rand_valid got %0b expected %0b (cycle %0d)", rsp_valid, exp_rv, c);
      end
      if (exp_rv) begin
        checks++; if (rsp_p !== exp_p || rsp_id !== exp_id) begin
          errors++; $display("[TB] FAIL rand_rsp got id %0b p %0d expected %0b %0d", rsp_id, rsp_p, exp_id, exp_p);
        end
      end
      acc = exp_any;
      hs  = exp_rv && rsp_ready;
      if (acc) begin
        exp_id = exp_win;
        exp_p  = exp_win ? prod(req1_a, req1_b) : prod(req0_a, req0_b);
      end
      tick();
      if (hs) pending = 1'b0;
      if (acc) begin
        pending = 1'b1;
        age = 0;
        m_last = exp_win;
      end else if (pending) begin
        age++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < SETTLE + 3; i++) tick();
  endtask

  task automatic test_sweep(input int sel, input int settle);
    int n;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        sw_a = 4'(a);
        sw_b = 4'(b);
        sw_valid[sel] = 1'b1;
        tick();
        sw_valid[sel] = 1'b0;
        n = 0;
        do begin
          tick();
          n++;
        end while (sw_rsp_valid[sel] !== 1'b1 && n < 20);
        checks++; if (sw_rsp_valid[sel] !== 1'b1 || n != settle) begin
          errors++; $display("[TB] FAIL sweep_latency got %0d expected %0d (settle %0d a %0d b %0d)", n, settle, settle, a, b);
        end
        checks++; if (sw_rsp_p[sel] !== prod(4'(a), 4'(b)) || sw_rsp_p[sel][2*N] !== 1'b0) begin
          errors++; $display("[TB] FAIL sweep_p got %0d expected %0d (settle %0d)", sw_rsp_p[sel], a * b, settle);
        end
        tick();
      end
    end
  endtask

  initial begin
    sw_valid[0] = 1'b0;
    sw_valid[1] = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_operand_hold();
    test_reset_mid();
    test_random();
    test_sweep(0, 1);
    test_sweep(1, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
